// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment driver: per-slot blanking, hex decode,
// and a pending/active double buffer that only swaps on frame boundaries.
module seven_seg_scan_ctrl #(
  parameter int unsigned DIGIT_TICKS = 50000,
  parameter int unsigned BLANK_TICKS = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [3:0]  an,
  output logic        frame_start,
  output logic        pending
);

  localparam int unsigned CNT_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_DRIVE = CNT_W'(BLANK_TICKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_DRIVE
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       idx, idx_nx;
  logic [15:0]      act_value, act_value_nx, buf_value;
  logic [3:0]       act_dp, act_dp_nx, buf_dp;
  logic [3:0]       act_en, act_en_nx, buf_en;
  logic             pending_nx;
  logic             frame_end;
  logic             lit;
  logic [3:0]       nib;
  logic [6:0]       seg_nx;
  logic             dp_n_nx;
  logic [3:0]       an_nx;
  logic             frame_start_nx;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h7E;
      4'h1: hex_to_seg = 7'h30;
      4'h2: hex_to_seg = 7'h6D;
      4'h3: hex_to_seg = 7'h79;
      4'h4: hex_to_seg = 7'h33;
      4'h5: hex_to_seg = 7'h5B;
      4'h6: hex_to_seg = 7'h5F;
      4'h7: hex_to_seg = 7'h70;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h7B;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h1F;
      4'hC: hex_to_seg = 7'h4E;
      4'hD: hex_to_seg = 7'h3D;
      4'hE: hex_to_seg = 7'h4F;
      default: hex_to_seg = 7'h47;
    endcase
  endfunction

  // Pins are registered from the next-state view so they line up with cnt/idx.
  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    idx_nx         = idx;
    act_value_nx   = act_value;
    act_dp_nx      = act_dp;
    act_en_nx      = act_en;
    pending_nx     = pending;
    frame_end      = 1'b0;
    lit            = 1'b0;
    nib            = '0;
    seg_nx         = 7'h7F;
    dp_n_nx        = 1'b1;
    an_nx          = 4'hF;
    frame_start_nx = 1'b0;

    if (state == S_IDLE) begin
      cnt_nx = '0;
      idx_nx = '0;
    end else if (cnt == CNT_LAST) begin
      cnt_nx    = '0;
      idx_nx    = idx + 2'd1;
      frame_end = (idx == 2'd3);
    end else begin
      cnt_nx = cnt + CNT_W'(1);
    end

    state_nx = (cnt_nx < CNT_DRIVE) ? S_BLANK : S_DRIVE;

    // Buffer contents from before this edge win; a same-edge upd stays pending.
    if (frame_end && pending) begin
      act_value_nx = buf_value;
      act_dp_nx    = buf_dp;
      act_en_nx    = buf_en;
      pending_nx   = 1'b0;
    end
    if (upd) pending_nx = 1'b1;

    nib = 4'(act_value_nx >> {idx_nx, 2'b00});
    lit = (state_nx == S_DRIVE) && act_en_nx[idx_nx];
    if (lit) begin
      an_nx   = ~(4'b0001 << idx_nx);
      seg_nx  = ~hex_to_seg(nib);
      dp_n_nx = ~act_dp_nx[idx_nx];
    end
    frame_start_nx = (idx_nx == 2'd0) && (cnt_nx == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      act_value   <= '0;
      act_dp      <= '0;
      act_en      <= '0;
      buf_value   <= '0;
      buf_dp      <= '0;
      buf_en      <= '0;
      pending     <= 1'b0;
      seg         <= 7'h7F;
      dp_n        <= 1'b1;
      an          <= 4'hF;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      act_value   <= act_value_nx;
      act_dp      <= act_dp_nx;
      act_en      <= act_en_nx;
      pending     <= pending_nx;
      seg         <= seg_nx;
      dp_n        <= dp_n_nx;
      an          <= an_nx;
      frame_start <= frame_start_nx;
      if (upd) begin
        buf_value <= value;
        buf_dp    <= dp_in;
        buf_en    <= digit_en;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: frame-position reference model checked every
// cycle, a vector table of display patterns, and hand sequences for corner cases.
module tb_seven_seg_scan_ctrl;

  localparam int DT = 8;
  localparam int BT = 2;
  localparam int FRAME = 4 * DT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        upd = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame_start;
  logic        pending;

  seven_seg_scan_ctrl #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (
    .clk(clk), .rst_n(rst_n), .upd(upd), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .seg(seg), .dp_n(dp_n), .an(an),
    .frame_start(frame_start), .pending(pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] dec_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference state: p = cycles since the first running cycle after reset.
  bit          started = 0;
  int          p = 0;
  logic [23:0] mbuf = '0;
  logic [23:0] mact = '0;
  bit          mpend = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      started = 0; p = 0; mbuf = '0; mact = '0; mpend = 0;
    end else begin
      if (!started) begin
        started = 1;
        p = 0;
      end else begin
        if ((p % FRAME) == FRAME - 1 && mpend) begin
          mact  = mbuf;
          mpend = 0;
        end
        p++;
      end
      if (upd) begin
        mbuf  = {value, dp_in, digit_en};
        mpend = 1;
      end
    end
  endtask

  task automatic model_compare();
    logic [3:0]  e_an = 4'hF;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;
    logic        e_fs = 1'b0;
    logic [15:0] v;
    int          d;
    if (started) begin
      d = (p / DT) % 4;
      v = mact[23:8];
      if ((p % DT) >= BT && mact[d]) begin
        e_an  = 4'hF;
        e_an[d] = 1'b0;
        e_seg = ~dec_tbl[v[d*4 +: 4]];
        e_dp  = ~mact[4 + d];
      end
      e_fs = ((p % FRAME) == 0);
    end
    chk("model_an", 32'(an), 32'(e_an));
    chk("model_seg", 32'(seg), 32'(e_seg));
    chk("model_dp_n", 32'(dp_n), 32'(e_dp));
    chk("model_frame_start", 32'(frame_start), 32'(e_fs));
    chk("model_pending", 32'(pending), 32'(mpend));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    model_compare();
    upd = 1'b0;
  endtask

  task automatic wait_pos(input int modulus, input int target, input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((p % modulus) != target && n < 2 * FRAME);
    if ((p % modulus) != target) chk({"wait_", name}, 32'(p % modulus), 32'(target));
  endtask

  task automatic do_upd(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en);
    value = v; dp_in = dp; digit_en = en; upd = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [27:0] seg;
    logic [15:0] an;
    logic [3:0]  dpn;
  } vec_t;

  vec_t vecs [4];
  int   fs_count;
  int   an_on;

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 4'b1111, {7'h4F, 7'h12, 7'h06, 7'h4C},
                {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b1111};
    vecs[1] = '{16'h0000, 4'b0001, 4'b0101, {7'h7F, 7'h01, 7'h7F, 7'h01},
                {4'b1111, 4'b1011, 4'b1111, 4'b1110}, 4'b1110};
    vecs[2] = '{16'h89AB, 4'b1010, 4'b1111, {7'h00, 7'h04, 7'h08, 7'h60},
                {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b0101};
    vecs[3] = '{16'hCDEF, 4'b1111, 4'b1000, {7'h31, 7'h7F, 7'h7F, 7'h7F},
                {4'b0111, 4'b1111, 4'b1111, 4'b1111}, 4'b0111};

    // Reset, then 64 idle cycles: dark pins, frame_start twice.
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_fs", 32'(frame_start), 32'h0);
    rst_n = 1'b1;
    fs_count = 0;
    an_on = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (frame_start) fs_count++;
      if (an != 4'hF || seg != 7'h7F) an_on++;
      if (i == 0) chk("first_frame_start", 32'(frame_start), 32'h1);
    end
    chk("idle_fs_count", 32'(fs_count), 32'd2);
    chk("idle_pins_lit", 32'(an_on), 32'd0);

    // Vector table: each pattern takes effect at the next frame.
    for (int k = 0; k < 4; k++) begin
      do_upd(vecs[k].value, vecs[k].dp, vecs[k].en);
      wait_pos(FRAME, 0, "frame");
      for (int d = 0; d < 4; d++) begin
        wait_pos(DT, BT, "drive");
        chk($sformatf("vec%0d_d%0d_an", k, d), 32'(an), 32'(vecs[k].an[d*4 +: 4]));
        chk($sformatf("vec%0d_d%0d_seg", k, d), 32'(seg), 32'(vecs[k].seg[d*7 +: 7]));
        chk($sformatf("vec%0d_d%0d_dp", k, d), 32'(dp_n), 32'(vecs[k].dpn[d]));
      end
    end

    // Two updates in one frame: last one wins, pending clears at boundary.
    wait_pos(FRAME, 5, "dbl_a");
    do_upd(16'h8888, 4'h0, 4'hF);
    chk("dbl_pending_1", 32'(pending), 32'h1);
    repeat (3) tick();
    do_upd(16'hF0F0, 4'h0, 4'hF);
    wait_pos(FRAME, FRAME - 1, "dbl_b");
    chk("dbl_pending_pre", 32'(pending), 32'h1);
    tick();
    chk("dbl_pending_post", 32'(pending), 32'h0);
    wait_pos(DT, BT, "dbl_d0");
    chk("dbl_d0_seg", 32'(seg), 32'h01);
    wait_pos(DT, BT, "dbl_d1");
    chk("dbl_d1_seg", 32'(seg), 32'h38);

    // Update on the boundary edge: older buffer shown now, newer one next frame.
    wait_pos(FRAME, 10, "bnd_a");
    do_upd(16'h0005, 4'h0, 4'hF);
    wait_pos(FRAME, FRAME - 1, "bnd_b");
    do_upd(16'h0007, 4'h0, 4'hF);
    chk("bnd_pos", 32'(p % FRAME), 32'd0);
    chk("bnd_pending", 32'(pending), 32'h1);
    wait_pos(DT, BT, "bnd_d0");
    chk("bnd_old_seg", 32'(seg), 32'h24);
    wait_pos(FRAME, FRAME - 1, "bnd_c");
    tick();
    chk("bnd_pending_clr", 32'(pending), 32'h0);
    wait_pos(DT, BT, "bnd_d0b");
    chk("bnd_new_seg", 32'(seg), 32'h0F);

    // Reset pulse mid-DRIVE of digit 2 discards pending and active data.
    wait_pos(FRAME, 2 * DT + 3, "rst_a");
    do_upd(16'h1234, 4'h0, 4'hF);
    chk("rst_pre_an", 32'(an), 32'b1011);
    rst_n = 1'b0;
    tick();
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_pending", 32'(pending), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_fs", 32'(frame_start), 32'h1);
    an_on = 0;
    repeat (FRAME) begin
      tick();
      if (an != 4'hF) an_on++;
    end
    chk("rst_dark_frame", 32'(an_on), 32'd0);

    // Random traffic against the model, with occasional resets.
    for (int i = 0; i < 900; i++) begin
      value    = 16'($urandom);
      dp_in    = 4'($urandom);
      digit_en = 4'($urandom);
      upd      = ($urandom_range(0, 9) == 0);
      rst_n    = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
